// File: rtl/mem_bus_pkg.sv
// Shared definitions for the on-chip memory bus initiators: access sizes,
// response error codes, initiator FSM states and the alignment check.
package mem_bus_pkg;

  // Access size encoding carried on req_size
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Response error codes carried on resp_err
  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_NODEV    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // Initiator transaction states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // A request is misaligned when it does not fit inside one bus word on its
  // natural boundary. The reserved size code is treated the same way so it
  // never reaches the bus.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addrLo[0];
      SZ_W:    bad = (addrLo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a CPU-side request and a 32-bit word bus.
// Store side replicates data onto every lane and builds the byte mask;
// load side shifts the addressed bytes down and extends them.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  i_stSize,
  input  logic [1:0]  i_stAddrLo,
  input  logic [31:0] i_stData,
  output logic [31:0] o_busWdata,
  output logic [3:0]  o_busWmask,
  input  logic [1:0]  i_ldSize,
  input  logic [1:0]  i_ldAddrLo,
  input  logic        i_ldSigned,
  input  logic [31:0] i_busRdata,
  output logic [31:0] o_ldData
);

  logic [31:0] w_shifted;

  assign w_shifted = i_busRdata >> {i_ldAddrLo, 3'b000};

  // Replicate store data across lanes so the responder can pick any lane;
  // the mask alone decides which bytes land.
  always_comb begin
    o_busWdata = 32'h0;
    o_busWmask = 4'b0000;
    case (i_stSize)
      SZ_B: begin
        o_busWdata = {4{i_stData[7:0]}};
        o_busWmask = 4'b0001 << i_stAddrLo;
      end
      SZ_H: begin
        o_busWdata = {2{i_stData[15:0]}};
        o_busWmask = 4'b0011 << {i_stAddrLo[1], 1'b0};
      end
      SZ_W: begin
        o_busWdata = i_stData;
        o_busWmask = 4'b1111;
      end
      default: begin
        o_busWdata = 32'h0;
        o_busWmask = 4'b0000;
      end
    endcase
  end

  // Bring the addressed byte/half down to bit 0 and extend it; words pass as-is.
  always_comb begin
    o_ldData = i_busRdata;
    case (i_ldSize)
      SZ_B:    o_ldData = i_ldSigned ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                     : {24'h0, w_shifted[7:0]};
      SZ_H:    o_ldData = i_ldSigned ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                     : {16'h0, w_shifted[15:0]};
      default: o_ldData = i_busRdata;
    endcase
  end

endmodule

// File: rtl/mem_bus_initiator.sv
// Memory bus initiator: takes one CPU load/store at a time, runs a single
// word-aligned bus transaction and returns extended load data plus an error.
module mem_bus_initiator
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  output logic        bus_wen,
  output logic        bus_ren,
  input  logic [31:0] bus_rdata,
  input  logic        bus_done,
  input  logic        bus_active
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t      r_state;
  state_t      w_stateNext;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_countNext;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_addrLo;

  logic [31:0] r_busAddr;
  logic [31:0] r_busWdata;
  logic [3:0]  r_busWmask;
  logic [31:0] r_respRdata;
  logic [1:0]  r_respErr;

  logic        w_accept;
  logic        w_misalign;
  logic        w_respLoad;
  logic [1:0]  w_respErrNext;
  logic [31:0] w_respRdataNext;
  logic [31:0] w_alignWdata;
  logic [3:0]  w_alignWmask;
  logic [31:0] w_ldData;

  // Store lanes come from the live request (used at accept); load extract
  // uses the latched request against the responder's data.
  mem_lane_align u_align (
    .i_stSize   (req_size),
    .i_stAddrLo (req_addr[1:0]),
    .i_stData   (req_wdata),
    .o_busWdata (w_alignWdata),
    .o_busWmask (w_alignWmask),
    .i_ldSize   (r_size),
    .i_ldAddrLo (r_addrLo),
    .i_ldSigned (r_signed),
    .i_busRdata (bus_rdata),
    .o_ldData   (w_ldData)
  );

  assign w_misalign = isMisaligned(req_size, req_addr[1:0]);

  // Next-state, strobe and response selection. Strobes exist only in ISSUE
  // and are gated by bus_active so an undecoded address never sees one.
  // bus_done is deliberately not looked at in ISSUE: a responder may still
  // be showing done from the previous transaction.
  always_comb begin
    w_stateNext     = r_state;
    w_countNext     = r_count;
    w_accept        = 1'b0;
    w_respLoad      = 1'b0;
    w_respErrNext   = ERR_OK;
    w_respRdataNext = 32'h0;
    bus_ren         = 1'b0;
    bus_wen         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (w_misalign) begin
            w_stateNext   = ST_RESP;
            w_respLoad    = 1'b1;
            w_respErrNext = ERR_MISALIGN;
          end else begin
            w_stateNext = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        bus_ren     = bus_active & ~r_we;
        bus_wen     = bus_active & r_we;
        w_countNext = '0;
        if (!bus_active) begin
          w_stateNext   = ST_RESP;
          w_respLoad    = 1'b1;
          w_respErrNext = ERR_NODEV;
        end else begin
          w_stateNext = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus_done) begin
          w_stateNext     = ST_RESP;
          w_respLoad      = 1'b1;
          w_respErrNext   = ERR_OK;
          w_respRdataNext = r_we ? 32'h0 : w_ldData;
        end else begin
          w_countNext = r_count + CW'(1);
          if (w_countNext == CW'(TIMEOUT_CYCLES)) begin
            w_stateNext   = ST_RESP;
            w_respLoad    = 1'b1;
            w_respErrNext = ERR_TIMEOUT;
          end
        end
      end
      ST_RESP: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // State and wait-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  // Latch the request at accept; bus address/data/mask only move for requests
  // that will actually reach the bus, and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_size     <= SZ_B;
      r_signed   <= 1'b0;
      r_addrLo   <= 2'b00;
      r_busAddr  <= 32'h0;
      r_busWdata <= 32'h0;
      r_busWmask <= 4'b0000;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addrLo <= req_addr[1:0];
      if (!w_misalign) begin
        r_busAddr  <= {req_addr[31:2], 2'b00};
        r_busWdata <= w_alignWdata;
        r_busWmask <= req_we ? w_alignWmask : 4'b0000;
      end
    end
  end

  // Response payload is captured on the transition into RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_respRdata <= 32'h0;
      r_respErr   <= ERR_OK;
    end else if (w_respLoad) begin
      r_respRdata <= w_respRdataNext;
      r_respErr   <= w_respErrNext;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_respRdata;
  assign resp_err   = r_respErr;
  assign bus_addr   = r_busAddr;
  assign bus_wdata  = r_busWdata;
  assign bus_wmask  = r_busWmask;

endmodule
